// File: rtl/egress_hdr_pkg.sv
// Shared definitions for the egress header rewrite stage: first-word field
// offsets, the IPv4 ethertype, TUSER port-byte positions and FSM states.
package egress_hdr_pkg;

  localparam int unsigned DST_MAC_LSB = 208;
  localparam int unsigned SRC_MAC_LSB = 160;
  localparam int unsigned ETYPE_LSB   = 144;
  localparam int unsigned TTL_LSB     = 72;
  localparam int unsigned PROTO_LSB   = 64;
  localparam int unsigned CKSUM_LSB   = 48;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;

  localparam int unsigned TUSER_SRC_PORT_POS = 16;
  localparam int unsigned TUSER_DST_PORT_POS = 24;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    BODY,
    DROP
  } state_t;

endpackage

// File: rtl/ip_cksum_incr.sv
// Incremental IPv4 header checksum update (RFC 1624) for a single changed
// 16-bit header word; purely combinational.
module ip_cksum_incr (
  input  logic [15:0] old_cksum,
  input  logic [15:0] old_word,
  input  logic [15:0] new_word,
  output logic [15:0] new_cksum
);

  logic [15:0] delta;
  logic [16:0] sum;

  // The word only ever decreases here (TTL >= 2 on entry), so the plain
  // difference equals the ones-complement difference and is added back to HC.
  always_comb begin
    delta     = old_word - new_word;
    sum       = {1'b0, old_cksum} + {1'b0, delta};
    new_cksum = sum[15:0] + {15'd0, sum[16]};
  end

endmodule

// File: rtl/egress_header_rewrite.sv
// Egress MAC rewrite, TTL decrement with incremental checksum and TUSER
// destination-port stamping. Optional flood broadcast: EGRESS_BCAST_SRCMAC_EN.
module egress_header_rewrite
  import egress_hdr_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH   = 32,
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int SRC_PORT_POS         = TUSER_SRC_PORT_POS,
  parameter int DST_PORT_POS         = TUSER_DST_PORT_POS
) (
  input  logic                              AXI_ACLK,
  input  logic                              AXI_RESETN,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    S_AXIS_TDATA,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  S_AXIS_TSTRB,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   S_AXIS_TUSER,
  input  logic                              S_AXIS_TVALID,
  input  logic                              S_AXIS_TLAST,
  output logic                              S_AXIS_TREADY,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    M_AXIS_TDATA,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  M_AXIS_TSTRB,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
  output logic                              M_AXIS_TVALID,
  output logic                              M_AXIS_TLAST,
  input  logic                              M_AXIS_TREADY,
  input  logic                              LKP_VALID,
  output logic                              LKP_READY,
  input  logic [7:0]                        LKP_PORT,
  input  logic [47:0]                       LKP_DST_MAC,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     mac0_low,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     mac0_high,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     mac1_low,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     mac1_high,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     mac2_low,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     mac2_high,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     mac3_low,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     mac3_high,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     reset,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     forwarded_count,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     ttl_drop_count
);

  localparam int unused_src_port_pos = SRC_PORT_POS;

  state_t state, state_n;

  logic [7:0]  lkp_port_q;
  logic [47:0] lkp_mac_q;
  logic        out_free, take, fwd_inc, drop_inc;
  logic [15:0] etype, old_ck, new_ck;
  logic [7:0]  ttl, proto;
  logic        is_ipv4, mac_hit, ttl_expired;
  logic [47:0] src_mac, dst_mac;
  logic [C_S_AXIS_DATA_WIDTH-1:0]  hdr_data;
  logic [C_S_AXIS_TUSER_WIDTH-1:0] hdr_user;

  logic unused_mac_bits;
  assign unused_mac_bits = ^{mac0_high[C_S_AXI_DATA_WIDTH-1:16], mac1_high[C_S_AXI_DATA_WIDTH-1:16],
                             mac2_high[C_S_AXI_DATA_WIDTH-1:16], mac3_high[C_S_AXI_DATA_WIDTH-1:16]};

  assign etype  = S_AXIS_TDATA[ETYPE_LSB +: 16];
  assign ttl    = S_AXIS_TDATA[TTL_LSB +: 8];
  assign proto  = S_AXIS_TDATA[PROTO_LSB +: 8];
  assign old_ck = S_AXIS_TDATA[CKSUM_LSB +: 16];

  assign is_ipv4     = (etype == ETHERTYPE_IPV4);
  assign mac_hit     = lkp_port_q[0] | lkp_port_q[2] | lkp_port_q[4] | lkp_port_q[6];
  assign ttl_expired = is_ipv4 && mac_hit && (ttl <= 8'd1);
  assign out_free    = !M_AXIS_TVALID || M_AXIS_TREADY;

  ip_cksum_incr u_cksum (
    .old_cksum (old_ck),
    .old_word  ({ttl, proto}),
    .new_word  ({ttl - 8'd1, proto}),
    .new_cksum (new_ck)
  );

  // Lowest even (MAC) port wins when the lookup is multi-hot.
  always_comb begin
    if (lkp_port_q[0])      src_mac = {mac0_high[15:0], mac0_low};
    else if (lkp_port_q[2]) src_mac = {mac1_high[15:0], mac1_low};
    else if (lkp_port_q[4]) src_mac = {mac2_high[15:0], mac2_low};
    else                    src_mac = {mac3_high[15:0], mac3_low};
  end

`ifdef EGRESS_BCAST_SRCMAC_EN
  logic flood;
  assign flood   = ($countones({lkp_port_q[6], lkp_port_q[4], lkp_port_q[2], lkp_port_q[0]}) > 1);
  assign dst_mac = flood ? 48'hFFFF_FFFF_FFFF : lkp_mac_q;
`else
  assign dst_mac = lkp_mac_q;
`endif

  always_comb begin
    hdr_data = S_AXIS_TDATA;
    hdr_user = S_AXIS_TUSER;
    hdr_user[DST_PORT_POS +: 8] = lkp_port_q;
    if (is_ipv4 && mac_hit) begin
      hdr_data[DST_MAC_LSB +: 48] = dst_mac;
      hdr_data[SRC_MAC_LSB +: 48] = src_mac;
      hdr_data[TTL_LSB +: 8]      = ttl - 8'd1;
      hdr_data[CKSUM_LSB +: 16]   = new_ck;
    end
  end

  always_comb begin
    state_n       = state;
    S_AXIS_TREADY = 1'b0;
    LKP_READY     = 1'b0;
    take          = 1'b0;
    fwd_inc       = 1'b0;
    drop_inc      = 1'b0;
    case (state)
      IDLE: if (LKP_VALID) state_n = HDR;
      HDR: begin
        S_AXIS_TREADY = out_free;
        if (S_AXIS_TVALID && out_free) begin
          LKP_READY = 1'b1;
          if (ttl_expired) begin
            drop_inc = 1'b1;
            state_n  = S_AXIS_TLAST ? IDLE : DROP;
          end else begin
            take    = 1'b1;
            fwd_inc = 1'b1;
            state_n = S_AXIS_TLAST ? IDLE : BODY;
          end
        end
      end
      BODY: begin
        S_AXIS_TREADY = out_free;
        if (S_AXIS_TVALID && out_free) begin
          take = 1'b1;
          if (S_AXIS_TLAST) state_n = IDLE;
        end
      end
      DROP: begin
        S_AXIS_TREADY = 1'b1;
        if (S_AXIS_TVALID && S_AXIS_TLAST) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) begin
      state      <= IDLE;
      lkp_port_q <= '0;
      lkp_mac_q  <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && LKP_VALID) begin
        lkp_port_q <= LKP_PORT;
        lkp_mac_q  <= LKP_DST_MAC;
      end
    end
  end

  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) begin
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TDATA  <= '0;
      M_AXIS_TSTRB  <= '0;
      M_AXIS_TUSER  <= '0;
      M_AXIS_TLAST  <= 1'b0;
    end else if (take) begin
      M_AXIS_TVALID <= 1'b1;
      M_AXIS_TDATA  <= (state == HDR) ? hdr_data : S_AXIS_TDATA;
      M_AXIS_TUSER  <= (state == HDR) ? hdr_user : S_AXIS_TUSER;
      M_AXIS_TSTRB  <= S_AXIS_TSTRB;
      M_AXIS_TLAST  <= S_AXIS_TLAST;
    end else if (M_AXIS_TREADY) begin
      M_AXIS_TVALID <= 1'b0;
    end
  end

  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) begin
      forwarded_count <= '0;
      ttl_drop_count  <= '0;
    end else if (reset == C_S_AXI_DATA_WIDTH'(1)) begin
      forwarded_count <= '0;
      ttl_drop_count  <= '0;
    end else begin
      if (fwd_inc && forwarded_count != '1) forwarded_count <= forwarded_count + 1'b1;
      if (drop_inc && ttl_drop_count != '1) ttl_drop_count <= ttl_drop_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_egress_header_rewrite.sv
// Randomized, model-checked bench for egress_header_rewrite.
module tb_egress_header_rewrite;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [255:0] s_tdata = '0;
  logic [31:0]  s_tstrb = '0;
  logic [127:0] s_tuser = '0;
  logic         s_tvalid = 1'b0, s_tlast = 1'b0, s_tready;
  logic [255:0] m_tdata;
  logic [31:0]  m_tstrb;
  logic [127:0] m_tuser;
  logic         m_tvalid, m_tlast, m_tready = 1'b1;
  logic         lkp_valid = 1'b0, lkp_ready;
  logic [7:0]   lkp_port = '0;
  logic [47:0]  lkp_dst_mac = '0;
  logic [31:0]  mac_lo [4];
  logic [31:0]  mac_hi [4];
  logic [31:0]  reg_reset = '0;
  logic [31:0]  fwd_cnt, drop_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [255:0] data;
    logic [127:0] user;
    logic [31:0]  strb;
    logic         last;
  } beat_t;

  beat_t pkt[$];
  beat_t exp_q[$];
  beat_t obs_q[$];
  int unsigned exp_fwd = 0, exp_drop = 0;

  always #5 clk = ~clk;

  egress_header_rewrite dut (
    .AXI_ACLK(clk), .AXI_RESETN(rst_n),
    .S_AXIS_TDATA(s_tdata), .S_AXIS_TSTRB(s_tstrb), .S_AXIS_TUSER(s_tuser),
    .S_AXIS_TVALID(s_tvalid), .S_AXIS_TLAST(s_tlast), .S_AXIS_TREADY(s_tready),
    .M_AXIS_TDATA(m_tdata), .M_AXIS_TSTRB(m_tstrb), .M_AXIS_TUSER(m_tuser),
    .M_AXIS_TVALID(m_tvalid), .M_AXIS_TLAST(m_tlast), .M_AXIS_TREADY(m_tready),
    .LKP_VALID(lkp_valid), .LKP_READY(lkp_ready), .LKP_PORT(lkp_port), .LKP_DST_MAC(lkp_dst_mac),
    .mac0_low(mac_lo[0]), .mac0_high(mac_hi[0]), .mac1_low(mac_lo[1]), .mac1_high(mac_hi[1]),
    .mac2_low(mac_lo[2]), .mac2_high(mac_hi[2]), .mac3_low(mac_lo[3]), .mac3_high(mac_hi[3]),
    .reset(reg_reset), .forwarded_count(fwd_cnt), .ttl_drop_count(drop_cnt)
  );

  always @(negedge clk)
    if (rst_n && m_tvalid && m_tready) obs_q.push_back('{m_tdata, m_tuser, m_tstrb, m_tlast});

  function automatic logic [7:0] get_b(input logic [255:0] d, input int n);
    return d[255-8*n -: 8];
  endfunction

  function automatic logic [255:0] put_b(input logic [255:0] d, input int n, input logic [7:0] v);
    d[255-8*n -: 8] = v;
    return d;
  endfunction

  task automatic build_pkt(input int unsigned n, input logic [15:0] et, input logic [7:0] ttl,
                           input logic [7:0] proto, input logic [15:0] hc);
    beat_t b;
    pkt.delete();
    for (int unsigned i = 0; i < n; i++) begin
      for (int unsigned k = 0; k < 8; k++) b.data[k*32 +: 32] = $urandom;
      for (int unsigned k = 0; k < 4; k++) b.user[k*32 +: 32] = $urandom;
      b.strb = $urandom;
      b.last = (i == n - 1);
      if (i == 0) begin
        b.data = put_b(b.data, 12, et[15:8]);
        b.data = put_b(b.data, 13, et[7:0]);
        b.data = put_b(b.data, 22, ttl);
        b.data = put_b(b.data, 23, proto);
        b.data = put_b(b.data, 24, hc[15:8]);
        b.data = put_b(b.data, 25, hc[7:0]);
      end
      pkt.push_back(b);
    end
  endtask

  // Reference behaviour in byte terms: appends expected beats and bumps counters.
  task automatic model_pkt(input logic [7:0] port, input logic [47:0] dmac);
    beat_t b;
    int sel, ttl, s, evens;
    logic [15:0] et;
    logic [47:0] smac, dm;
    b  = pkt[0];
    et = {get_b(b.data, 12), get_b(b.data, 13)};
    ttl = get_b(b.data, 22);
    sel = -1;
    evens = 0;
    for (int p = 3; p >= 0; p--) if (port[2*p]) begin sel = p; evens++; end
    if (et == 16'h0800 && sel >= 0 && ttl <= 1) begin
      exp_drop++;
      return;
    end
    exp_fwd++;
    if (et == 16'h0800 && sel >= 0) begin
      smac = {mac_hi[sel][15:0], mac_lo[sel]};
      dm = dmac;
`ifdef EGRESS_BCAST_SRCMAC_EN
      if (evens > 1) dm = 48'hFFFF_FFFF_FFFF;
`endif
      for (int n = 0; n < 6; n++) begin
        b.data = put_b(b.data, n, dm[47-8*n -: 8]);
        b.data = put_b(b.data, 6 + n, smac[47-8*n -: 8]);
      end
      b.data = put_b(b.data, 22, 8'(ttl - 1));
      s = {get_b(b.data, 24), get_b(b.data, 25)} + 256;
      if (s > 65535) s = s - 65535;
      b.data = put_b(b.data, 24, 8'(s >> 8));
      b.data = put_b(b.data, 25, 8'(s));
    end
    b.user[31:24] = port;
    exp_q.push_back(b);
    for (int i = 1; i < pkt.size(); i++) exp_q.push_back(pkt[i]);
  endtask

  task automatic send_pkt(input logic [7:0] port, input logic [47:0] dmac, input int unsigned stop_after);
    int unsigned idx = 0, budget = 0;
    bit acc, lk;
    @(posedge clk); #1;
    lkp_valid = 1'b1; lkp_port = port; lkp_dst_mac = dmac;
    while (idx < pkt.size() && budget < 300) begin
      s_tvalid = 1'b1;
      s_tdata = pkt[idx].data; s_tuser = pkt[idx].user;
      s_tstrb = pkt[idx].strb; s_tlast = pkt[idx].last;
      @(negedge clk);
      acc = s_tready;
      lk = lkp_ready;
      @(posedge clk); #1;
      if (lk) lkp_valid = 1'b0;
      if (acc) begin
        idx++;
        if (stop_after != 0 && idx == stop_after) break;
      end
      budget++;
    end
    s_tvalid = 1'b0;
    lkp_valid = 1'b0;
  endtask

  task automatic wait_out(input int unsigned n);
    int unsigned t = 0;
    while (obs_q.size() < n && t < 300) begin @(negedge clk); t++; end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset;
    #12;
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_m_tvalid got %b want 0", m_tvalid); end
    checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL reset_s_tready got %b want 0", s_tready); end
    checks++; if (lkp_ready !== 1'b0) begin errors++; $display("FAIL reset_lkp_ready got %b want 0", lkp_ready); end
    checks++; if (fwd_cnt !== 32'd0) begin errors++; $display("FAIL reset_fwd_cnt got %0d want 0", fwd_cnt); end
    checks++; if (drop_cnt !== 32'd0) begin errors++; $display("FAIL reset_drop_cnt got %0d want 0", drop_cnt); end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    logic [15:0] et; logic [7:0] ttl; logic [7:0] proto; logic [15:0] hc;
    logic [7:0] port; int unsigned n; logic [7:0] ettl; logic [15:0] ehc; int esel;
  } dcase_t;

  task automatic test_directed;
    dcase_t c [3];
    logic [47:0] dm;
    c[0] = '{16'h0800, 8'h40, 8'h06, 16'hB1E6, 8'h04, 2, 8'h3F, 16'hB2E6, 1};
    c[1] = '{16'h0800, 8'h10, 8'h11, 16'hFF50, 8'h01, 3, 8'h0F, 16'h0051, 0};
    c[2] = '{16'h0806, 8'h40, 8'h06, 16'h1234, 8'h02, 2, 8'h40, 16'h1234, -1};
    for (int unsigned k = 0; k < 3; k++) begin
      dm = {$urandom, $urandom};
      build_pkt(c[k].n, c[k].et, c[k].ttl, c[k].proto, c[k].hc);
      model_pkt(c[k].port, dm);
      send_pkt(c[k].port, dm, 0);
      wait_out(exp_q.size());
      checks++;
      if (obs_q.size() != exp_q.size()) begin
        errors++; $display("FAIL directed%0d_beats got %0d want %0d", k, obs_q.size(), exp_q.size());
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          checks++;
          if ({obs_q[i].data, obs_q[i].user, obs_q[i].strb, obs_q[i].last} !==
              {exp_q[i].data, exp_q[i].user, exp_q[i].strb, exp_q[i].last}) begin
            errors++;
            $display("FAIL directed%0d_beat%0d got %h want %h", k, i,
                     {obs_q[i].data, obs_q[i].user, obs_q[i].strb, obs_q[i].last},
                     {exp_q[i].data, exp_q[i].user, exp_q[i].strb, exp_q[i].last});
          end
        end
        checks++; if (obs_q[0].data[79:72] !== c[k].ettl) begin errors++; $display("FAIL directed%0d_ttl got %h want %h", k, obs_q[0].data[79:72], c[k].ettl); end
        checks++; if (obs_q[0].data[63:48] !== c[k].ehc) begin errors++; $display("FAIL directed%0d_hc got %h want %h", k, obs_q[0].data[63:48], c[k].ehc); end
        checks++; if (obs_q[0].user[31:24] !== c[k].port) begin errors++; $display("FAIL directed%0d_tuser got %h want %h", k, obs_q[0].user[31:24], c[k].port); end
        if (c[k].esel >= 0) begin
          checks++;
          if (obs_q[0].data[207:160] !== {mac_hi[c[k].esel][15:0], mac_lo[c[k].esel]}) begin
            errors++; $display("FAIL directed%0d_srcmac got %h want %h", k, obs_q[0].data[207:160], {mac_hi[c[k].esel][15:0], mac_lo[c[k].esel]});
          end
        end else begin
          for (int i = 0; i < pkt.size(); i++) begin
            checks++; if (obs_q[i].data !== pkt[i].data) begin errors++; $display("FAIL directed%0d_passthru%0d got %h want %h", k, i, obs_q[i].data, pkt[i].data); end
          end
        end
      end
      checks++; if (fwd_cnt !== k + 1) begin errors++; $display("FAIL directed%0d_fwd_cnt got %0d want %0d", k, fwd_cnt, k + 1); end
      obs_q.delete(); exp_q.delete();
    end
  endtask

  task automatic test_ttl_drop;
    logic [47:0] dm = 48'h0200_0000_0001;
    build_pkt(3, 16'h0800, 8'h01, 8'h06, 16'h4321);
    model_pkt(8'h01, dm);
    send_pkt(8'h01, dm, 0);
    wait_out(1);
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL ttl_drop_beats got %0d want 0", obs_q.size()); end
    checks++; if (drop_cnt !== 32'd1) begin errors++; $display("FAIL ttl_drop_cnt got %0d want 1", drop_cnt); end
    obs_q.delete();
    build_pkt(2, 16'h0800, 8'h05, 8'h06, 16'h1000);
    model_pkt(8'h10, dm);
    send_pkt(8'h10, dm, 0);
    wait_out(exp_q.size());
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL after_drop_beats got %0d want %0d", obs_q.size(), exp_q.size());
    end else for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if ({obs_q[i].data, obs_q[i].user, obs_q[i].strb, obs_q[i].last} !==
          {exp_q[i].data, exp_q[i].user, exp_q[i].strb, exp_q[i].last}) begin
        errors++; $display("FAIL after_drop_beat%0d got %h want %h", i, obs_q[i].data, exp_q[i].data);
      end
    end
    checks++; if (fwd_cnt !== exp_fwd) begin errors++; $display("FAIL after_drop_fwd_cnt got %0d want %0d", fwd_cnt, exp_fwd); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_random;
    logic [15:0] ets [4];
    logic [7:0] port, ttl;
    logic [47:0] dm;
    ets[0] = 16'h0800; ets[1] = 16'h0800; ets[2] = 16'h0806; ets[3] = 16'h86DD;
    for (int unsigned p = 0; p < 24; p++) begin
      ttl = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      port = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      dm = {$urandom, $urandom};
      build_pkt($urandom_range(1, 4), ets[$urandom_range(0, 3)], ttl, 8'($urandom), 16'($urandom));
      model_pkt(port, dm);
      send_pkt(port, dm, 0);
    end
    wait_out(exp_q.size());
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL random_beats got %0d want %0d", obs_q.size(), exp_q.size());
    end else for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if ({obs_q[i].data, obs_q[i].user, obs_q[i].strb, obs_q[i].last} !==
          {exp_q[i].data, exp_q[i].user, exp_q[i].strb, exp_q[i].last}) begin
        errors++; $display("FAIL random_beat%0d got %h/%h want %h/%h", i, obs_q[i].data, obs_q[i].user, exp_q[i].data, exp_q[i].user);
      end
    end
    checks++; if (fwd_cnt !== exp_fwd) begin errors++; $display("FAIL random_fwd_cnt got %0d want %0d", fwd_cnt, exp_fwd); end
    checks++; if (drop_cnt !== exp_drop) begin errors++; $display("FAIL random_drop_cnt got %0d want %0d", drop_cnt, exp_drop); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_backpressure;
    logic [47:0] dm = 48'h0A0B_0C0D_0E0F;
    logic [255:0] prev_data;
    bit prev_stall = 0;
    int stalls = 0;
    build_pkt(5, 16'h0800, 8'h20, 8'h06, 16'h5555);
    model_pkt(8'h40, dm);
    fork
      send_pkt(8'h40, dm, 0);
      begin
        for (int unsigned t = 0; t < 40; t++) begin
          @(posedge clk); #1;
          m_tready = ~m_tready;
          @(negedge clk);
          if (prev_stall) begin
            checks++;
            if (m_tvalid !== 1'b1 || m_tdata !== prev_data) begin
              errors++; $display("FAIL bp_stable cycle %0d got v=%b %h want v=1 %h", t, m_tvalid, m_tdata, prev_data);
            end
          end
          if (m_tvalid && !m_tready) begin
            stalls++;
            checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL bp_s_tready cycle %0d got %b want 0", t, s_tready); end
          end
          prev_stall = m_tvalid && !m_tready;
          prev_data = m_tdata;
        end
      end
    join
    m_tready = 1'b1;
    wait_out(exp_q.size());
    checks++; if (stalls == 0) begin errors++; $display("FAIL bp_stalls got 0 want >0"); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL bp_beats got %0d want %0d", obs_q.size(), exp_q.size());
    end else for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if ({obs_q[i].data, obs_q[i].user, obs_q[i].last} !== {exp_q[i].data, exp_q[i].user, exp_q[i].last}) begin
        errors++; $display("FAIL bp_beat%0d got %h want %h", i, obs_q[i].data, exp_q[i].data);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_counter_clear;
    logic [47:0] dm = 48'h1111_2222_3333;
    @(posedge clk); #1; reg_reset = 32'd1;
    build_pkt(1, 16'h0800, 8'h08, 8'h06, 16'h0001);
    model_pkt(8'h01, dm);
    send_pkt(8'h01, dm, 0);
    wait_out(exp_q.size());
    checks++; if (fwd_cnt !== 32'd0) begin errors++; $display("FAIL clear_fwd_cnt got %0d want 0", fwd_cnt); end
    checks++; if (drop_cnt !== 32'd0) begin errors++; $display("FAIL clear_drop_cnt got %0d want 0", drop_cnt); end
    checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL clear_beats got %0d want 1", obs_q.size()); end
    reg_reset = '0;
    exp_fwd = 0; exp_drop = 0;
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid;
    logic [47:0] dm = 48'h3C3C_3C3C_3C3C;
    build_pkt(6, 16'h0800, 8'h30, 8'h06, 16'hABCD);
    send_pkt(8'h04, dm, 3);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL midrst_m_tvalid got %b want 0", m_tvalid); end
    checks++; if (fwd_cnt !== 32'd0) begin errors++; $display("FAIL midrst_fwd_cnt got %0d want 0", fwd_cnt); end
    checks++; if (s_tready !== 1'b0 || lkp_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready got %b%b want 00", s_tready, lkp_ready); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    obs_q.delete(); exp_q.delete();
    exp_fwd = 0; exp_drop = 0;
    build_pkt(3, 16'h0800, 8'h40, 8'h06, 16'hB1E6);
    model_pkt(8'h04, dm);
    send_pkt(8'h04, dm, 0);
    wait_out(exp_q.size());
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL midrst_beats got %0d want %0d", obs_q.size(), exp_q.size());
    end else for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if ({obs_q[i].data, obs_q[i].user, obs_q[i].strb, obs_q[i].last} !==
          {exp_q[i].data, exp_q[i].user, exp_q[i].strb, exp_q[i].last}) begin
        errors++; $display("FAIL midrst_beat%0d got %h want %h", i, obs_q[i].data, exp_q[i].data);
      end
    end
    checks++; if (fwd_cnt !== 32'd1) begin errors++; $display("FAIL midrst_fwd_after got %0d want 1", fwd_cnt); end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      mac_lo[i] = $urandom;
      mac_hi[i] = $urandom;
    end
    test_reset;
    test_directed;
    test_ttl_drop;
    test_random;
    test_backpressure;
    test_counter_clear;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
